// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-back arbiter with LSU result FIFO and busy scoreboard
module regfile_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        AluValid,
    input  logic [4:0]  AluRd,
    input  logic [31:0] AluData,
    output logic        AluStall,
    input  logic        IssueValid,
    input  logic [4:0]  IssueRd,
    output logic        IssueReady,
    input  logic        LsuValid,
    input  logic [4:0]  LsuRd,
    input  logic [31:0] LsuData,
    output logic        LsuReady,
    input  logic [4:0]  ReadAddr1,
    input  logic [4:0]  ReadAddr2,
    output logic        Busy1,
    output logic        Busy2,
    output logic        RegWrite,
    output logic [4:0]  WriteAddr,
    output logic [31:0] WriteData
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [36:0]   r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [CW-1:0] r_starve;
    logic [31:0]   r_busy;
    logic          r_from_lsu;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_alu_take;
    logic [4:0]    w_head_rd;
    logic [31:0]   w_head_data;
    logic [31:0]   w_set_mask;
    logic [31:0]   w_clr_mask;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign {w_head_rd, w_head_data} = r_mem[r_rd_ptr[AW-1:0]];

    assign LsuReady   = !w_full;
    assign w_push     = LsuValid && !w_full;
    assign AluStall   = (r_starve == LIMIT) && !w_empty;
    // A stalled ALU cannot win, so ALU and FIFO winners are mutually exclusive.
    assign w_alu_take = AluValid && !AluStall;
    assign w_pop      = !w_empty && (AluStall || !AluValid);

    assign IssueReady = !r_busy[IssueRd] || (IssueRd == 5'd0);
    assign Busy1      = r_busy[ReadAddr1];
    assign Busy2      = r_busy[ReadAddr2];

    assign w_set_mask = (IssueValid && IssueReady) ? (32'h1 << IssueRd) : 32'h0;
    assign w_clr_mask = (RegWrite && r_from_lsu) ? (32'h1 << WriteAddr) : 32'h0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {LsuRd, LsuData};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_pop || w_empty) begin
            r_starve <= '0;
        end else if (w_alu_take) begin
            r_starve <= r_starve + CW'(1);
        end
    end

    // Busy clears on the edge that ends the write cycle since the regfile has no bypass.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy | w_set_mask) & ~w_clr_mask & ~32'h1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite   <= 1'b0;
            WriteAddr  <= 5'd0;
            WriteData  <= 32'd0;
            r_from_lsu <= 1'b0;
        end else if (w_pop) begin
            RegWrite   <= (w_head_rd != 5'd0);
            WriteAddr  <= w_head_rd;
            WriteData  <= w_head_data;
            r_from_lsu <= 1'b1;
        end else if (w_alu_take) begin
            RegWrite   <= (AluRd != 5'd0);
            WriteAddr  <= AluRd;
            WriteData  <= AluData;
            r_from_lsu <= 1'b0;
        end else begin
            RegWrite   <= 1'b0;
            r_from_lsu <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        AluValid;
    logic [4:0]  AluRd;
    logic [31:0] AluData;
    logic        AluStall;
    logic        IssueValid;
    logic [4:0]  IssueRd;
    logic        IssueReady;
    logic        LsuValid;
    logic [4:0]  LsuRd;
    logic [31:0] LsuData;
    logic        LsuReady;
    logic [4:0]  ReadAddr1;
    logic [4:0]  ReadAddr2;
    logic        Busy1;
    logic        Busy2;
    logic        RegWrite;
    logic [4:0]  WriteAddr;
    logic [31:0] WriteData;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    regfile_wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst(rst),
        .AluValid(AluValid), .AluRd(AluRd), .AluData(AluData), .AluStall(AluStall),
        .IssueValid(IssueValid), .IssueRd(IssueRd), .IssueReady(IssueReady),
        .LsuValid(LsuValid), .LsuRd(LsuRd), .LsuData(LsuData), .LsuReady(LsuReady),
        .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2), .Busy1(Busy1), .Busy2(Busy2),
        .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic idle_inputs();
        AluValid   = 1'b0;
        LsuValid   = 1'b0;
        IssueValid = 1'b0;
    endtask

    function automatic exp_t mk(input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    // Monitor: every write the DUT emits must match the head of the expected queue.
    always @(negedge clk) begin
        if (RegWrite === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write",
                         WriteAddr, WriteData);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (WriteAddr !== e.addr || WriteData !== e.data) begin
                    errors++;
                    $display("FAIL write: got addr %0d data %0h expected addr %0d data %0h",
                             WriteAddr, WriteData, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        AluRd = 5'd0; AluData = 32'd0; IssueRd = 5'd7; LsuRd = 5'd0; LsuData = 32'd0;
        ReadAddr1 = 5'd7; ReadAddr2 = 5'd5;

        // Reset state
        repeat (2) tick();
        @(negedge clk);
        chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("rst_waddr", {27'd0, WriteAddr}, 32'd0);
        chk("rst_wdata", WriteData, 32'd0);
        chk("rst_lsuready", {31'd0, LsuReady}, 32'd1);
        chk("rst_issueready", {31'd0, IssueReady}, 32'd1);
        chk("rst_busy1", {31'd0, Busy1}, 32'd0);
        chk("rst_busy2", {31'd0, Busy2}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Single ALU write
        AluValid = 1'b1; AluRd = 5'd5; AluData = 32'hDEADBEEF;
        exp_q.push_back(mk(5'd5, 32'hDEADBEEF));
        tick();
        idle_inputs();
        repeat (2) tick();

        // Issue x7, LSU result three cycles later, busy lifetime
        IssueValid = 1'b1; IssueRd = 5'd7; ReadAddr1 = 5'd7;
        tick();
        IssueValid = 1'b0;
        @(negedge clk);
        chk("issue_busy1_c1", {31'd0, Busy1}, 32'd1);
        chk("issue_ready_busy", {31'd0, IssueReady}, 32'd0);
        repeat (2) tick();
        LsuValid = 1'b1; LsuRd = 5'd7; LsuData = 32'h1234;
        exp_q.push_back(mk(5'd7, 32'h1234));
        tick();
        LsuValid = 1'b0;
        @(negedge clk);
        chk("busy1_c4", {31'd0, Busy1}, 32'd1);
        tick();
        @(negedge clk);
        chk("busy1_write_cycle", {31'd0, Busy1}, 32'd1);
        chk("regwrite_c5", {31'd0, RegWrite}, 32'd1);
        tick();
        @(negedge clk);
        chk("busy1_c6", {31'd0, Busy1}, 32'd0);
        chk("issue_ready_c6", {31'd0, IssueReady}, 32'd1);
        repeat (2) tick();

        // Starvation: ALU every unstalled cycle, four LSU pushes back to back
        exp_q.push_back(mk(5'd20, 32'hA000));
        exp_q.push_back(mk(5'd20, 32'hA001));
        exp_q.push_back(mk(5'd20, 32'hA002));
        exp_q.push_back(mk(5'd20, 32'hA003));
        exp_q.push_back(mk(5'd11, 32'hB000));
        exp_q.push_back(mk(5'd20, 32'hA005));
        exp_q.push_back(mk(5'd20, 32'hA006));
        exp_q.push_back(mk(5'd20, 32'hA007));
        exp_q.push_back(mk(5'd12, 32'hB001));
        exp_q.push_back(mk(5'd13, 32'hB002));
        exp_q.push_back(mk(5'd14, 32'hB003));
        for (int c = 0; c <= 10; c++) begin
            AluValid = (c <= 7) && (c != 4);
            AluRd    = 5'd20;
            AluData  = 32'hA000 + 32'(c);
            LsuValid = (c < 4);
            LsuRd    = 5'(11 + c);
            LsuData  = 32'hB000 + 32'(c);
            @(negedge clk);
            chk($sformatf("stall_c%0d", c), {31'd0, AluStall}, (c == 4 || c == 8) ? 32'd1 : 32'd0);
            chk($sformatf("lsuready_c%0d", c), {31'd0, LsuReady}, (c == 4) ? 32'd0 : 32'd1);
            tick();
        end
        idle_inputs();
        repeat (3) tick();

        // rd==0 winners are consumed silently; x0 never becomes busy
        AluValid = 1'b1; AluRd = 5'd0; AluData = 32'hFFFF;
        LsuValid = 1'b1; LsuRd = 5'd0; LsuData = 32'h5555;
        IssueValid = 1'b1; IssueRd = 5'd0; ReadAddr1 = 5'd0;
        tick();
        idle_inputs();
        @(negedge clk);
        chk("x0_issueready", {31'd0, IssueReady}, 32'd1);
        chk("x0_busy1", {31'd0, Busy1}, 32'd0);
        tick();
        LsuValid = 1'b1; LsuRd = 5'd9; LsuData = 32'h99;
        exp_q.push_back(mk(5'd9, 32'h99));
        tick();
        LsuValid = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("x0_drained_lsuready", {31'd0, LsuReady}, 32'd1);
        chk("x0_drained_queue", 32'(exp_q.size()), 32'd0);

        // Reset with two queued entries and a busy register
        IssueValid = 1'b1; IssueRd = 5'd3; ReadAddr1 = 5'd3;
        tick();
        IssueValid = 1'b0;
        AluValid = 1'b1; AluRd = 5'd21; AluData = 32'h2100;
        LsuValid = 1'b1; LsuRd = 5'd15; LsuData = 32'h1500;
        exp_q.push_back(mk(5'd21, 32'h2100));
        tick();
        AluData = 32'h2101;
        LsuRd = 5'd16; LsuData = 32'h1600;
        exp_q.push_back(mk(5'd21, 32'h2101));
        @(negedge clk);
        chk("pre_rst_busy1", {31'd0, Busy1}, 32'd1);
        tick();
        idle_inputs();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy1", {31'd0, Busy1}, 32'd0);
        chk("post_rst_issueready", {31'd0, IssueReady}, 32'd1);
        chk("post_rst_lsuready", {31'd0, LsuReady}, 32'd1);
        chk("post_rst_regwrite", {31'd0, RegWrite}, 32'd0);
        repeat (6) tick();
        @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
